load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits directly upstream of the word-addressed data memory in the MIPS datapath. Converts CPU load and store requests into word-level memory reads and writes:
- byte, halfword and word sizes
- signed or unsigned loads
- read-modify-write for sub-word stores
- alignment checking

A small FSM drives the memory and presents a busy/done handshake to the CPU stall logic.

Parameters:
MEM_WORDS, 16, number of 32-bit words in the attached data memory; used only by the optional bounds check.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  CPU access request; sampled only in IDLE
is_store  input  1  1 = store, 0 = load
size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  input  32  byte address
wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle completion pulse
rdata  output  32  extended load result; valid with done, held until next done
misalign  output  1  valid with done; held until next done
addr_fault  output  1  valid with done; held until next done (see Optional Feature)
mem_addr  output  32  word index to data memory (addr[31:2] zero-extended)
mem_wdata  output  32  merged write word
mem_write  output  1  memory write strobe
mem_read  output  1  memory read strobe
mem_rdata  input  32  memory read data; combinational, same cycle as mem_read

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, misalign, addr_fault, mem_read, mem_write = 0.
  - rdata, mem_addr, mem_wdata, all internal latches = 0.
- States: IDLE, READ, WRITE, RESP. Memory outputs are Moore-decoded from the state and latched registers.
  - mem_read=1 only in READ; mem_write=1 only in WRITE; never both.
  - mem_addr is held constant from READ through WRITE; it is 0 in IDLE.
- IDLE:
  - On a posedge with req=1, latch addr, wdata, size, sign_ext and is_store.
  - misaligned := (size=01 and addr[0]) or (size=10 and addr[1:0]!=0) or size=11.
  - Next state:
    - misaligned -> RESP, with no memory access.
    - load -> READ.
    - store word -> WRITE.
    - store byte or half -> READ.
- READ: capture mem_rdata into the word buffer at the posedge. Next state: load -> RESP; sub-word store -> WRITE.
- WRITE:
  - Store word: mem_wdata = wdata.
  - Store half: replace lane addr[1] ([15:0] or [31:16]) of the buffer with wdata[15:0].
  - Store byte: replace bits [8k+7:8k], k = addr[1:0], with wdata[7:0].
  - Little-endian lane order.
  - Next state: RESP.
- RESP:
  - done=1 for exactly one cycle.
  - For loads, rdata gets the extracted lane, sign- or zero-extended per sign_ext; word loads pass through unchanged.
  - For stores, rdata is unchanged.
  - Next state: IDLE.
- Latency, counted in cycles after the req-sampling edge until done:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - misaligned: 1
- req outside IDLE (including during RESP) is ignored; there is no queueing. The CPU holds req until done.
- Reset mid-operation aborts immediately: mem_write and mem_read drop asynchronously and no done pulse is produced. A store reset during READ never writes.

Optional Feature:
Macro LSU_BOUNDS_CHECK_EN.
- Defined: in IDLE, an aligned request with addr[31:2] >= MEM_WORDS goes straight to RESP with addr_fault=1 and performs no memory access. Misalignment takes priority, so both flags may be 1 together.
- Undefined: addr_fault is tied to 0 and the index is passed through unchecked.

Test Plan:
- Word store 0xDEADBEEF to addr 0x8 -> one WRITE cycle with mem_addr=2, mem_wdata=0xDEADBEEF, no mem_read; done 2 cycles after req; misalign=0.
- Memory word 2 = 0xDEADBEEF; lb addr 0xB, sign_ext=1 -> rdata=0xFFFFFFDE; lbu same addr -> 0x000000DE; each done 2 cycles after req.
- Word 2 = 0xDEADBEEF; sh wdata=0x00001234 to addr 0x8 -> READ then WRITE with mem_wdata=0xDEAD1234; to addr 0xA -> 0x1234BEEF; done 3 cycles after req.
- lh addr 0x9, and lw addr 0x6 -> done 1 cycle after req with misalign=1; mem_read and mem_write stay 0 throughout.
- sb to addr 0x4; assert rst_n=0 during READ -> mem_write never pulses, all outputs 0, memory word 1 unchanged; first req after reset release completes normally.
- With LSU_BOUNDS_CHECK_EN and MEM_WORDS=16: lw addr 0x40 -> addr_fault=1, no memory strobe. Without the macro -> mem_read with mem_addr=16 and addr_fault=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-addressed memory.
// Optional bounds check enabled by defining LSU_BOUNDS_CHECK_EN.
module load_store_unit #(
  parameter int MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        addr_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [1:0]  r_size;
  logic        r_sign;
  logic        r_store;

  logic        w_mis;
  logic        w_oob;
  logic [4:0]  w_sh;
  logic [31:0] w_rsh;
  logic [31:0] w_ext;
  logic [31:0] w_mask;
  logic [31:0] w_data;
  logic [31:0] w_merge;

  assign w_mis = (size == 2'b01 && addr[0])
              || (size == 2'b10 && addr[1:0] != 2'b00)
              || (size == 2'b11);

`ifdef LSU_BOUNDS_CHECK_EN
  assign w_oob = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
`else
  logic w_unused_oob;
  assign w_unused_oob = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
  assign w_oob = 1'b0;
`endif

  // Lane shift amount: byte lane for loads/byte stores, half lane for halves
  assign w_sh  = (r_size == 2'b01) ? {r_addr[1], 4'b0000}
                                   : {r_addr[1:0], 3'b000};
  assign w_rsh = mem_rdata >> w_sh;

  // Load lane extraction and extension
  always_comb begin
    w_ext = mem_rdata;
    case (r_size)
      2'b00:   w_ext = {{24{r_sign & w_rsh[7]}}, w_rsh[7:0]};
      2'b01:   w_ext = {{16{r_sign & w_rsh[15]}}, w_rsh[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  // Store merge of new lane into the buffered word
  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    w_data = r_wdata;
    case (r_size)
      2'b00: begin
        w_mask = 32'h0000_00FF << w_sh;
        w_data = {24'h0, r_wdata[7:0]} << w_sh;
      end
      2'b01: begin
        w_mask = 32'h0000_FFFF << w_sh;
        w_data = {16'h0, r_wdata[15:0]} << w_sh;
      end
      default: begin
        w_mask = 32'hFFFF_FFFF;
        w_data = r_wdata;
      end
    endcase
    w_merge = (r_buf & ~w_mask) | (w_data & w_mask);
  end

  // Next-state and Moore memory/handshake outputs
  always_comb begin
    w_next    = r_state;
    busy      = (r_state != IDLE);
    done      = (r_state == RESP);
    mem_read  = (r_state == READ);
    mem_write = (r_state == WRITE);
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (r_state == READ || r_state == WRITE)
      mem_addr = {2'b00, r_addr[31:2]};
    if (r_state == WRITE)
      mem_wdata = w_merge;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (w_mis || w_oob)
            w_next = RESP;
          else if (is_store && size == 2'b10)
            w_next = WRITE;
          else
            w_next = READ;
        end
      end
      READ:    w_next = r_store ? WRITE : RESP;
      WRITE:   w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Request latches, read buffer and held response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_buf      <= 32'h0;
      r_size     <= 2'b00;
      r_sign     <= 1'b0;
      r_store    <= 1'b0;
      rdata      <= 32'h0;
      misalign   <= 1'b0;
      addr_fault <= 1'b0;
    end else begin
      if (r_state == IDLE && req) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_size  <= size;
        r_sign  <= sign_ext;
        r_store <= is_store;
      end
      if (r_state == READ)
        r_buf <= mem_rdata;
      if (r_state != RESP && w_next == RESP) begin
        misalign   <= (r_state == IDLE) && w_mis;
        addr_fault <= (r_state == IDLE) && w_oob;
        if (r_state == READ && !r_store)
          rdata <= w_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// Table of accesses plus a reset-abort sequence.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misalign, addr_fault;
  logic        mem_write, mem_read;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:15];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .is_store(is_store),
    .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
    .addr_fault(addr_fault), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'd16) ? mem[mem_addr[3:0]] : 32'h0;

  always @(posedge clk)
    if (mem_write && mem_addr < 32'd16)
      mem[mem_addr[3:0]] <= mem_wdata;

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    int          nr;
    int          nw;
    logic [31:0] ewd;
    logic [31:0] ema;
    logic [31:0] erd;
    logic        emis;
    logic        eflt;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(logic st, logic [1:0] sz, logic sx,
                              logic [31:0] a, logic [31:0] wd,
                              int lat, int nr, int nw,
                              logic [31:0] ewd, logic [31:0] ema,
                              logic [31:0] erd, logic emis,
                              logic eflt);
    vec_t t;
    t.st = st; t.sz = sz; t.sx = sx; t.a = a; t.wd = wd;
    t.lat = lat; t.nr = nr; t.nw = nw; t.ewd = ewd;
    t.ema = ema; t.erd = erd; t.emis = emis; t.eflt = eflt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input int idx);
    int          cyc = 0;
    int          nr = 0;
    int          nw = 0;
    logic [31:0] wd = 32'h0;
    logic [31:0] ma = 32'h0;
    logic        got = 1'b0;
    logic        both = 1'b0;
    @(negedge clk);
    req = 1'b1; is_store = t.st; size = t.sz;
    sign_ext = t.sx; addr = t.a; wdata = t.wd;
    while (!got && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_read) begin nr++; ma = mem_addr; end
      if (mem_write) begin nw++; wd = mem_wdata; ma = mem_addr; end
      if (mem_read && mem_write) both = 1'b1;
      if (done) got = 1'b1;
    end
    chk($sformatf("v%0d_done", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d_lat", idx), 32'(cyc), 32'(t.lat));
    chk($sformatf("v%0d_nread", idx), 32'(nr), 32'(t.nr));
    chk($sformatf("v%0d_nwrite", idx), 32'(nw), 32'(t.nw));
    chk($sformatf("v%0d_both", idx), 32'(both), 32'd0);
    if (t.nw > 0)
      chk($sformatf("v%0d_wdata", idx), wd, t.ewd);
    if (t.nr + t.nw > 0)
      chk($sformatf("v%0d_maddr", idx), ma, t.ema);
    chk($sformatf("v%0d_rdata", idx), rdata, t.erd);
    chk($sformatf("v%0d_mis", idx), 32'(misalign), 32'(t.emis));
    chk($sformatf("v%0d_flt", idx), 32'(addr_fault), 32'(t.eflt));
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_pulse", idx), {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // st sz sx addr wdata lat nr nw ewd ema erd mis flt
    v.push_back(mk(1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 2, 0, 1,
                   32'hDEADBEEF, 2, 32'h0, 0, 0));
    v.push_back(mk(0, 2'b00, 1, 32'hB, 32'h0, 2, 1, 0,
                   0, 2, 32'hFFFFFFDE, 0, 0));
    v.push_back(mk(0, 2'b00, 0, 32'hB, 32'h0, 2, 1, 0,
                   0, 2, 32'h000000DE, 0, 0));
    v.push_back(mk(1, 2'b01, 0, 32'h8, 32'h00001234, 3, 1, 1,
                   32'hDEAD1234, 2, 32'h000000DE, 0, 0));
    v.push_back(mk(0, 2'b10, 0, 32'h8, 32'h0, 2, 1, 0,
                   0, 2, 32'hDEAD1234, 0, 0));
    v.push_back(mk(1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 2, 0, 1,
                   32'hDEADBEEF, 2, 32'hDEAD1234, 0, 0));
    v.push_back(mk(1, 2'b01, 0, 32'hA, 32'h00001234, 3, 1, 1,
                   32'h1234BEEF, 2, 32'hDEAD1234, 0, 0));
    v.push_back(mk(0, 2'b01, 1, 32'h8, 32'h0, 2, 1, 0,
                   0, 2, 32'hFFFFBEEF, 0, 0));
    v.push_back(mk(0, 2'b01, 0, 32'hA, 32'h0, 2, 1, 0,
                   0, 2, 32'h00001234, 0, 0));
    v.push_back(mk(0, 2'b01, 1, 32'h9, 32'h0, 1, 0, 0,
                   0, 0, 32'h00001234, 1, 0));
    v.push_back(mk(0, 2'b10, 0, 32'h6, 32'h0, 1, 0, 0,
                   0, 0, 32'h00001234, 1, 0));
    v.push_back(mk(1, 2'b11, 0, 32'h0, 32'h55, 1, 0, 0,
                   0, 0, 32'h00001234, 1, 0));
    v.push_back(mk(1, 2'b00, 0, 32'h9, 32'h000000A5, 3, 1, 1,
                   32'h1234A5EF, 2, 32'h00001234, 0, 0));
    v.push_back(mk(0, 2'b00, 1, 32'h9, 32'h0, 2, 1, 0,
                   0, 2, 32'hFFFFFFA5, 0, 0));
    v.push_back(mk(1, 2'b10, 0, 32'h4, 32'h11223344, 2, 0, 1,
                   32'h11223344, 1, 32'hFFFFFFA5, 0, 0));
`ifdef LSU_BOUNDS_CHECK_EN
    v.push_back(mk(0, 2'b10, 0, 32'h40, 32'h0, 1, 0, 0,
                   0, 0, 32'hFFFFFFA5, 0, 1));
`else
    v.push_back(mk(0, 2'b10, 0, 32'h40, 32'h0, 2, 1, 0,
                   0, 16, 32'h0, 0, 0));
`endif

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_flags", {30'h0, misalign, addr_fault}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (v[i]) run(v[i], i);

    // Byte store aborted by reset while reading
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; size = 2'b00;
    sign_ext = 1'b0; addr = 32'h4; wdata = 32'h77;
    @(posedge clk); #1;
    chk("abort_read", 32'(mem_read), 32'd1);
    chk("abort_maddr", mem_addr, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("abort_hs", {30'h0, busy, done}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_maddr0", mem_addr, 32'h0);
    chk("abort_wdata0", mem_wdata, 32'h0);
    req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_hold", {29'h0, mem_write, busy, done}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_mem1", mem[1], 32'h11223344);

    run(mk(0, 2'b10, 0, 32'h4, 32'h0, 2, 1, 0,
           0, 1, 32'h11223344, 0, 0), 100);
    chk("post_mem1", mem[1], 32'h11223344);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
